mem_access_unit: RTL and testbench

//  Initiator side of the byte-addressed data memory port: the MIPS memory stage issues
//  one load/store request; this block sequences the memory's level-sensitive read/write

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the byte-addressed data memory port. Takes one load/store
//   request from the memory stage, drives the level-sensitive read/write strobes
//   for MEM_LAT cycles each, aligns and extends load data, and performs a
//   read-modify-write for SB/SH because the memory only writes whole words.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : request present
//   req_ready    : high only while idle; request accepted on valid & ready
//   req_op       : 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
//   req_addr     : byte address
//   req_wdata    : store data (low byte/half used for SB/SH)
//   resp_valid   : one-cycle completion pulse
//   resp_err     : misaligned request, no memory access made (valid with resp_valid)
//   resp_rdata   : load result (0 for stores and errors)
//   mem_addr     : word-aligned memory address
//   mem_wdata    : full word to write
//   mem_rdata    : word read from memory
//   mem_read     : memory read strobe
//   mem_write    : memory write strobe
module mem_access_unit #(
  parameter int ADDR_W  = 15,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  state_t        state;
  op_t           op_q;
  logic [1:0]    lane_q;
  logic [15:0]   wdata_q;
  logic [CW-1:0] cnt;

  op_t           op_in;
  logic          misaligned;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;
  logic [31:0]   merged;

  assign req_ready = (state == IDLE);
  assign op_in     = op_t'(req_op);

  always_comb begin
    misaligned = 1'b0;
    case (op_in)
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      OP_LW, OP_SW:         misaligned = |req_addr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  // Lane extraction and merge both work straight off mem_rdata so the word
  // only needs to be valid on the last read cycle.
  always_comb begin
    byte_sel  = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = '0;
    case (op_q)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LW:   load_data = mem_rdata;
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (op_q == OP_SH) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LB;
      lane_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q     <= op_in;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            cnt      <= '0;
            if (misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (op_in == OP_SW) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state    <= RD;
              mem_read <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            mem_read <= 1'b0;
            if (op_q == OP_SB || op_q == OP_SH) begin
              state     <= WR;
              mem_write <= 1'b1;
              mem_wdata <= merged;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            mem_write  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int ADDR_W  = 15;
  localparam int MEM_LAT = 2;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                         LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_read;
  logic              mem_write;

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  // Word-wide memory model
  logic [31:0] mem [0:8191];
  assign mem_rdata = mem[mem_addr[14:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[14:2]] <= mem_wdata;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts strobes and pops/compares on each response pulse
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (mem_read && mem_write) overlap++;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
      acc_q.delete();
    end else begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=1 required=0");
        end else begin
          e = sb_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
          chk({e.name, "_err"},   {31'h0, resp_err}, {31'h0, e.err});
          chk({e.name, "_rdata"}, resp_rdata, e.rdata);
          chk({e.name, "_lat"},   32'(cyc - a + 1), 32'(e.lat));
          chk({e.name, "_nrd"},   32'(rd_cnt), 32'(e.nrd));
          chk({e.name, "_nwr"},   32'(wr_cnt), 32'(e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
      if (req_valid && req_ready) acc_q.push_back(cyc + 1);
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic issue(input string nm, input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd,
                       input int lat, input int nrd, input int nwr);
    bit acc = 0;
    exp_t e;
    e.name = nm; e.err = err; e.rdata = rd; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    sb_q.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1;
        break;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_accept actual=0 required=1", nm);
    end
    @(posedge clk);
    #2;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #3;
    end
    chk("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  localparam int L1 = MEM_LAT + 1;
  localparam int L2 = 2 * MEM_LAT + 1;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready",      {31'h0, req_ready},  32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'd0);
    chk("rst_strobes",    {30'h0, mem_read, mem_write}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_addr",   32'(mem_addr), 32'd0);
    chk("rst_mem_wdata",  mem_wdata, 32'd0);
    rst = 1'b0;

    // SW / LW round trip
    issue("sw10", SW, 15'h0010, 32'hDEADBEEF, 0, 32'h0, L1, 0, MEM_LAT);
    issue("lw10", LW, 15'h0010, 32'h0, 0, 32'hDEADBEEF, L1, MEM_LAT, 0);
    // Sub-word loads
    issue("lb13",  LB,  15'h0013, 32'h0, 0, 32'hFFFFFFDE, L1, MEM_LAT, 0);
    issue("lbu13", LBU, 15'h0013, 32'h0, 0, 32'h000000DE, L1, MEM_LAT, 0);
    issue("lh10",  LH,  15'h0010, 32'h0, 0, 32'hFFFFBEEF, L1, MEM_LAT, 0);
    issue("lhu12", LHU, 15'h0012, 32'h0, 0, 32'h0000DEAD, L1, MEM_LAT, 0);
    drain();
    chk("mem_after_sw", mem[4], 32'hDEADBEEF);

    // Read-modify-write stores
    issue("sb11", SB, 15'h0011, 32'h00000055, 0, 32'h0, L2, MEM_LAT, MEM_LAT);
    drain();
    chk("mem_after_sb", mem[4], 32'hDEAD55EF);
    issue("sh12", SH, 15'h0012, 32'h00001234, 0, 32'h0, L2, MEM_LAT, MEM_LAT);
    drain();
    chk("mem_after_sh", mem[4], 32'h123455EF);

    // Misaligned requests
    issue("lw12_mis", LW, 15'h0012, 32'h0, 1, 32'h0, 1, 0, 0);
    issue("sh11_mis", SH, 15'h0011, 32'hFFFFFFFF, 1, 32'h0, 1, 0, 0);
    drain();
    chk("mem_after_err", mem[4], 32'h123455EF);

    // Busy SB with changing requests held on the inputs
    issue("sb10", SB, 15'h0010, 32'h000000AA, 0, 32'h0, L2, MEM_LAT, MEM_LAT);
    for (int i = 0; i < 50; i++) begin
      if (req_ready) break;
      req_valid = 1'b1;
      req_op    = (i % 2 == 0) ? SW : LB;
      req_addr  = 15'h0010;
      req_wdata = 32'h00000000;
      @(negedge clk);
      if (i == 0) chk("busy_ready", {31'h0, req_ready}, 32'd0);
      @(posedge clk);
      #2;
    end
    issue("lbu10", LBU, 15'h0010, 32'h0, 0, 32'h000000AA, L1, MEM_LAT, 0);
    issue("lw10b", LW,  15'h0010, 32'h0, 0, 32'h123455AA, L1, MEM_LAT, 0);
    issue("lh12",  LH,  15'h0012, 32'h0, 0, 32'h00001234, L1, MEM_LAT, 0);
    drain();
    chk("mem_after_busy", mem[4], 32'h123455AA);

    // Reset during the write phase of SW
    issue("sw20_abort", SW, 15'h0020, 32'hCAFEF00D, 0, 32'h0, L1, 0, MEM_LAT);
    chk("abort_in_wr", {31'h0, mem_write}, 32'd1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("abort_ready",      {31'h0, req_ready},  32'd1);
    chk("abort_strobes",    {30'h0, mem_read, mem_write}, 32'd0);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
    #1;
    rst = 1'b0;
    issue("lw10c", LW, 15'h0010, 32'h0, 0, 32'h123455AA, L1, MEM_LAT, 0);
    drain();
    repeat (4) @(posedge clk);
    #3;
    chk("strobe_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
